// File: rtl/pos_eval_seq_if.sv
// pos_eval_seq_if: config, operand and result handshake bundle for pos_eval_seq.
// master = stimulus / host side, slave = evaluator side.
interface pos_eval_seq_if #(
   parameter int N_IN   = 4,
   parameter int N_TERM = 8
);
   localparam int AW = $clog2(N_TERM);

   // clause table write port
   logic            cfg_we;
   logic [AW-1:0]   cfg_addr;
   logic [N_IN-1:0] cfg_care;
   logic [N_IN-1:0] cfg_neg;
   logic            cfg_en;
   logic            cfg_drop;

   // operand side
   logic            mode;
   logic            in_valid;
   logic            in_ready;
   logic [N_IN-1:0] in_x;

   // result side
   logic            out_valid;
   logic            out_ready;
   logic            out_f;
   logic            busy;

   modport master (
      output cfg_we, cfg_addr, cfg_care, cfg_neg, cfg_en,
      output mode, in_valid, in_x, out_ready,
      input  cfg_drop, in_ready, out_valid, out_f, busy
   );

   modport slave (
      input  cfg_we, cfg_addr, cfg_care, cfg_neg, cfg_en,
      input  mode, in_valid, in_x, out_ready,
      output cfg_drop, in_ready, out_valid, out_f, busy
   );
endinterface

// File: rtl/pos_eval_seq.sv
// pos_eval_seq: programmable sequential POS / SOP evaluator.
// Holds N_TERM clauses over an N_IN-bit operand and folds one clause per clock.
// Optional build macro POS_EARLY_EXIT_EN: leave EVAL the cycle after the
// accumulator reaches its dominant value (POS 0, SOP 1). out_f is the same
// in both builds; only latency differs.
module pos_eval_seq #(
   parameter int N_IN   = 4,
   parameter int N_TERM = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   pos_eval_seq_if.slave bus
);
   localparam int              AW       = $clog2(N_TERM);
   localparam logic [AW-1:0]   LAST_IDX = AW'(N_TERM - 1);

   typedef enum logic [1:0] {S_IDLE, S_EVAL, S_DONE} state_t;

   typedef struct packed {
      logic            en;
      logic [N_IN-1:0] care;
      logic [N_IN-1:0] neg;
   } clause_t;

   clause_t         r_tab [N_TERM];
   state_t          r_state;
   state_t          w_state_nxt;
   logic [N_IN-1:0] r_x;
   logic            r_mode;
   logic [AW-1:0]   r_idx;
   logic            r_acc;
   logic            r_last;
   logic            r_out_f;
   logic            r_cfg_drop;

   logic            w_accept;
   logic            w_finish;
   logic            w_acc_nxt;
   logic            w_pos_clause;
   logic            w_sop_term;
   logic [N_IN-1:0] w_lit;
   clause_t         w_cur;

   // Fold the clause addressed by r_idx into the accumulator
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      w_cur        = r_tab[r_idx];
      w_lit        = (r_x ^ w_cur.neg) & w_cur.care;
      w_pos_clause = |w_lit;                  // empty care -> 0
      w_sop_term   = &(w_lit | ~w_cur.care);  // empty care -> 1
      w_acc_nxt    = r_acc;                   // disabled clause is neutral
      if (w_cur.en) begin
         w_acc_nxt = r_mode ? (r_acc | w_sop_term) : (r_acc & w_pos_clause);
      end
   end

`ifdef POS_EARLY_EXIT_EN
   logic w_dom;
   // Result is decided once the accumulator holds the dominant value
   assign w_dom    = r_mode ? r_acc : ~r_acc;
   assign w_finish = r_last | w_dom;
`else
   assign w_finish = r_last;
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state logic and accept decode
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      case (r_state)
         S_IDLE: if (bus.in_valid) begin
            w_accept    = 1'b1;
            w_state_nxt = S_EVAL;
         end
         S_EVAL: if (w_finish)      w_state_nxt = S_DONE;
         S_DONE: if (bus.out_ready) w_state_nxt = S_IDLE;
         default:                   w_state_nxt = S_IDLE;
      endcase
   end

   // Operand capture, clause walk and result register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x     <= '0;
         r_mode  <= 1'b0;
         r_idx   <= '0;
         r_acc   <= 1'b1;
         r_last  <= 1'b0;
         r_out_f <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (w_accept) begin
               r_x    <= bus.in_x;
               r_mode <= bus.mode;
               r_idx  <= '0;
               r_acc  <= ~bus.mode;   // POS starts at 1, SOP at 0
               r_last <= 1'b0;
            end
            S_EVAL: begin
               if (w_finish) begin
                  r_out_f <= r_acc;
               end else begin
                  r_acc  <= w_acc_nxt;
                  r_last <= (r_idx == LAST_IDX);
                  r_idx  <= (r_idx == LAST_IDX) ? r_idx : r_idx + AW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Clause table: writes commit only in IDLE, so an evaluation never sees a change
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: this table is reset on purpose; an unprogrammed function must read as all clauses disabled.
      if (!rst_n) begin
         for (int i = 0; i < N_TERM; i++) r_tab[i] <= '0;
      end else if (bus.cfg_we && (r_state == S_IDLE) && (int'(bus.cfg_addr) < N_TERM)) begin
         r_tab[bus.cfg_addr] <= '{en: bus.cfg_en, care: bus.cfg_care, neg: bus.cfg_neg};
      end
   end

   // One-cycle flag for a write that arrived while busy and was discarded
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_cfg_drop <= 1'b0;
      else        r_cfg_drop <= bus.cfg_we && (r_state != S_IDLE);
   end

   assign bus.in_ready  = (r_state == S_IDLE);
   assign bus.busy      = (r_state != S_IDLE);
   assign bus.out_valid = (r_state == S_DONE);
   assign bus.out_f     = r_out_f;
   assign bus.cfg_drop  = r_cfg_drop;
endmodule

// File: tb/tb_pos_eval_seq.sv
// tb_pos_eval_seq: directed self-checking bench for pos_eval_seq.
// Expected latencies follow the POS_EARLY_EXIT_EN build macro.
module tb_pos_eval_seq;
   localparam int N_IN   = 4;
   localparam int N_TERM = 8;
`ifdef POS_EARLY_EXIT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   pos_eval_seq_if #(.N_IN(N_IN), .N_TERM(N_TERM)) bus ();

   pos_eval_seq #(.N_IN(N_IN), .N_TERM(N_TERM)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // inputs change and outputs are sampled 1 time unit after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // k = 1-based index of the deciding clause, N_TERM when nothing decides
   function automatic int lat_of(input int k);
      return EARLY ? k + 1 : N_TERM + 1;
   endfunction

   task automatic cfg(input logic [2:0] addr, input logic [3:0] care, input logic [3:0] neg, input logic en);
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = addr;
      bus.cfg_care = care;
      bus.cfg_neg  = neg;
      bus.cfg_en   = en;
      tick();
      bus.cfg_we   = 1'b0;
   endtask

   task automatic accept(input string tag, input logic [3:0] x, input logic m);
      bus.in_x     = x;
      bus.mode     = m;
      bus.in_valid = 1'b1;
      check({tag, "_in_ready"}, bus.in_ready, 1'b1);
      tick();
      bus.in_valid = 1'b0;
      bus.in_x     = ~x;     // operand must be held internally
      bus.mode     = ~m;
      check({tag, "_busy"}, bus.busy, 1'b1);
   endtask

   task automatic collect(input string tag, input logic exp_f, input int exp_lat,
                          input int elapsed, input int hold);
      int lat = elapsed;
      while (bus.out_valid !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_out_f"}, bus.out_f, exp_f);
      for (int i = 0; i < hold; i++) begin
         bus.in_valid = 1'b1;
         tick();
         check({tag, "_hold_valid"}, bus.out_valid, 1'b1);
         check({tag, "_hold_f"}, bus.out_f, exp_f);
         check({tag, "_hold_in_ready"}, bus.in_ready, 1'b0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check({tag, "_valid_drop"}, bus.out_valid, 1'b0);
      check({tag, "_back_idle"}, bus.in_ready, 1'b1);
   endtask

   task automatic run(input string tag, input logic [3:0] x, input logic m,
                      input logic exp_f, input int exp_lat);
      accept(tag, x, m);
      collect(tag, exp_f, exp_lat, 0, 0);
   endtask

   initial begin
      logic [3:0] negs [7];
      negs = '{4'h1, 4'h3, 4'h6, 4'hD, 4'hF, 4'h9, 4'hB};

      rst_n         = 1'b0;
      bus.cfg_we    = 1'b0;
      bus.cfg_addr  = '0;
      bus.cfg_care  = '0;
      bus.cfg_neg   = '0;
      bus.cfg_en    = 1'b0;
      bus.mode      = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_x      = '0;
      bus.out_ready = 1'b0;
      #1;
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_out_f",     bus.out_f,     1'b0);
      check("rst_cfg_drop",  bus.cfg_drop,  1'b0);
      check("rst_busy",      bus.busy,      1'b0);
      check("rst_in_ready",  bus.in_ready,  1'b1);
      tick();
      rst_n = 1'b1;
      tick();

      // POS table: clause i is false only when x == negs[i]
      for (int i = 0; i < 7; i++) cfg(3'(i), 4'hF, negs[i], 1'b1);
      run("pos_x0", 4'h0, 1'b0, 1'b1, lat_of(N_TERM));
      run("pos_x1", 4'h1, 1'b0, 1'b0, lat_of(1));

      // backpressure on x=D (clause 3 decides)
      accept("bp_xD", 4'hD, 1'b0);
      collect("bp_xD", 1'b0, lat_of(4), 0, 5);

      // write during EVAL is dropped
      accept("drop", 4'h1, 1'b0);
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = 3'd0;
      bus.cfg_care = 4'hF;
      bus.cfg_neg  = 4'h0;
      bus.cfg_en   = 1'b1;
      tick();
      bus.cfg_we = 1'b0;
      check("drop_pulse", bus.cfg_drop, 1'b1);
      tick();
      check("drop_pulse_end", bus.cfg_drop, 1'b0);
      collect("drop", 1'b0, lat_of(1), 2, 0);
      run("drop_rerun", 4'h1, 1'b0, 1'b0, lat_of(1));

      // write together with accept: clause0 becomes false for x=0
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = 3'd0;
      bus.cfg_care = 4'hF;
      bus.cfg_neg  = 4'h0;
      bus.cfg_en   = 1'b1;
      accept("wr_acc", 4'h0, 1'b0);
      bus.cfg_we = 1'b0;
      check("wr_acc_no_drop", bus.cfg_drop, 1'b0);
      collect("wr_acc", 1'b0, lat_of(1), 0, 0);

      // SOP: f = x1 & x0; out_ready held high during EVAL has no effect
      cfg(3'd0, 4'h3, 4'h0, 1'b1);
      for (int i = 1; i < 7; i++) cfg(3'(i), 4'hF, 4'h0, 1'b0);
      bus.out_ready = 1'b1;
      run("sop_x3", 4'h3, 1'b1, 1'b1, lat_of(1));
      run("sop_x2", 4'h2, 1'b1, 1'b0, lat_of(N_TERM));

      // reset in the middle of EVAL
      accept("rst_mid", 4'h5, 1'b0);
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      check("rst_mid_out_valid", bus.out_valid, 1'b0);
      check("rst_mid_busy",      bus.busy,      1'b0);
      check("rst_mid_in_ready",  bus.in_ready,  1'b1);
      check("rst_mid_out_f",     bus.out_f,     1'b0);
      tick();
      rst_n = 1'b1;
      tick();
      // cleared table: POS -> 1, SOP -> 0
      run("clr_pos", 4'hA, 1'b0, 1'b1, lat_of(N_TERM));
      run("clr_sop", 4'hF, 1'b1, 1'b0, lat_of(N_TERM));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
